mmio_cmd_queue: RTL and testbench

Memory-mapped command queue on the GPU-side parallel bus, directly downstream of the SPI-to-parallel bridge. Decodes single-cycle bus writes into a small register window, enqueues 32-bit command words pushed by the host, and presents them to the GPU command processor over a valid/ready stream. It also provides status readback on `o_bus_rdata` and an optional fill-level interrupt.

---
 rtl/gpu_mmio_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/mmio_cmd_queue.sv | 168 ++++++++++++++++
 tb/tb_mmio_cmd_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mmio_pkg.sv
// Shared register map, bit positions and queue state encoding for the
// MMIO command queue.
package gpu_mmio_pkg;

    localparam logic [1:0] CMD_PUSH_OFS   = 2'd0;
    localparam logic [1:0] STATUS_OFS     = 2'd1;
    localparam logic [1:0] CTRL_OFS       = 2'd2;
    localparam logic [1:0] IRQ_THRESH_OFS = 2'd3;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_FLUSH_BIT   = 1;
    localparam int CTRL_IRQ_EN_BIT  = 2;
    localparam int CTRL_OVF_CLR_BIT = 3;

    localparam int STATUS_COUNT_LSB = 0;
    localparam int STATUS_EMPTY_BIT = 8;
    localparam int STATUS_FULL_BIT  = 9;
    localparam int STATUS_OVF_BIT   = 10;
    localparam int STATUS_STATE_LSB = 11;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN      = 2'd1,
        DRAIN    = 2'd2
    } q_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with flush; a keep-head flush discards
// everything except the entry currently presented at the head.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic             flush_keep_head,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full-queue push needs.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            if (flush_keep_head && !empty) begin
                wr_ptr_d = rd_ptr_q + PW'(1);
                count_d  = CW'(1);
            end else begin
                rd_ptr_d = wr_ptr_q;
                count_d  = '0;
            end
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mmio_cmd_queue.sv
// Bus-mapped command queue feeding the GPU command processor.
// Define MMIO_CMD_QUEUE_IRQ_EN to build the threshold register and o_irq.
//
// state    | meaning
// DISABLED | stream idle, queue may still be preloaded
// RUN      | head presented whenever the queue is non-empty
// DRAIN    | disable requested mid-handshake; hold head until accepted
module mmio_cmd_queue
    import gpu_mmio_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_bus_we,
    input  logic [ADDR_WIDTH-1:0] i_bus_addr,
    input  logic [DATA_WIDTH-1:0] i_bus_wdata,
    output logic [DATA_WIDTH-1:0] o_bus_rdata,
    output logic                  o_cmd_valid,
    input  logic                  i_cmd_ready,
    output logic [DATA_WIDTH-1:0] o_cmd_data,
    output logic                  o_irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]         count;
    logic                  full, empty;
    logic                  hit, wr, push_wr, ctrl_wr;
    logic [1:0]            sel;
    logic                  pop, flush, keep_head;
    q_state_t              state_q, state_d;
    logic                  en_q, en_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [7:0]            thresh_rd;
    logic                  irq_en_rd;
    logic                  unused_addr_lsbs;

    assign hit              = (i_bus_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign sel              = i_bus_addr[3:2];
    assign wr               = i_bus_we && hit;
    assign push_wr          = wr && (sel == CMD_PUSH_OFS);
    assign ctrl_wr          = wr && (sel == CTRL_OFS);
    assign unused_addr_lsbs = ^i_bus_addr[1:0];

    assign o_cmd_valid = (state_q == DRAIN) || ((state_q == RUN) && !empty);
    assign pop         = o_cmd_valid && i_cmd_ready;
    assign keep_head   = o_cmd_valid && !i_cmd_ready;
    assign flush       = ctrl_wr && i_bus_wdata[CTRL_FLUSH_BIT];
    assign o_bus_rdata = rdata_q;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk             (clk),
        .rst             (rst),
        .push            (push_wr),
        .pop             (pop),
        .flush           (flush),
        .flush_keep_head (keep_head),
        .wdata           (i_bus_wdata),
        .rdata           (o_cmd_data),
        .count           (count),
        .full            (full),
        .empty           (empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            DISABLED: if (ctrl_wr && i_bus_wdata[CTRL_EN_BIT]) state_d = RUN;
            RUN: begin
                if (ctrl_wr && !i_bus_wdata[CTRL_EN_BIT]) begin
                    state_d = keep_head ? DRAIN : DISABLED;
                end
            end
            DRAIN: begin
                if (ctrl_wr && i_bus_wdata[CTRL_EN_BIT]) state_d = RUN;
                else if (i_cmd_ready)                     state_d = DISABLED;
            end
            default: state_d = DISABLED;
        endcase
    end

    always_comb begin
        en_d  = ctrl_wr ? i_bus_wdata[CTRL_EN_BIT] : en_q;
        ovf_d = ovf_q;
        if (ctrl_wr && i_bus_wdata[CTRL_OVF_CLR_BIT]) ovf_d = 1'b0;
        if (push_wr && full && !pop)                  ovf_d = 1'b1;
    end

    always_comb begin
        rdata_d = '0;
        if (hit) begin
            case (sel)
                STATUS_OFS: begin
                    rdata_d[STATUS_COUNT_LSB +: 8] = 8'(count);
                    rdata_d[STATUS_EMPTY_BIT]      = empty;
                    rdata_d[STATUS_FULL_BIT]       = full;
                    rdata_d[STATUS_OVF_BIT]        = ovf_q;
                    rdata_d[STATUS_STATE_LSB +: 2] = state_q;
                end
                CTRL_OFS: begin
                    rdata_d[CTRL_EN_BIT]     = en_q;
                    rdata_d[CTRL_IRQ_EN_BIT] = irq_en_rd;
                end
                IRQ_THRESH_OFS: rdata_d[7:0] = thresh_rd;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DISABLED;
            en_q    <= 1'b0;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MMIO_CMD_QUEUE_IRQ_EN
    logic       thresh_wr;
    logic [7:0] thresh_q, thresh_d;
    logic       irq_en_q, irq_en_d;
    logic       irq_q, irq_d;

    assign thresh_wr = wr && (sel == IRQ_THRESH_OFS);

    // A zero threshold disables the fill-level source; overflow still fires.
    always_comb begin
        thresh_d = thresh_wr ? i_bus_wdata[7:0] : thresh_q;
        irq_en_d = ctrl_wr ? i_bus_wdata[CTRL_IRQ_EN_BIT] : irq_en_q;
        irq_d    = irq_en_q && (((thresh_q != 8'd0) && (8'(count) >= thresh_q)) || ovf_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_q <= 8'd1;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            thresh_q <= thresh_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign thresh_rd = thresh_q;
    assign irq_en_rd = irq_en_q;
    assign o_irq     = irq_q;
`else
    assign thresh_rd = 8'd0;
    assign irq_en_rd = 1'b0;
    assign o_irq     = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_cmd_queue.sv
// Directed bench for mmio_cmd_queue: a per-cycle vector table plus
// hand-written sequences for overflow, flush, drain, reset and interrupt.
module tb_mmio_cmd_queue;

    localparam logic [31:0] A_PUSH = 32'h0000_1000;
    localparam logic [31:0] A_STAT = 32'h0000_1004;
    localparam logic [31:0] A_CTRL = 32'h0000_1008;
    localparam logic [31:0] A_THR  = 32'h0000_100C;
`ifdef MMIO_CMD_QUEUE_IRQ_EN
    localparam logic [31:0] EXP_THR_RST = 32'd1;
`else
    localparam logic [31:0] EXP_THR_RST = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_bus_we;
    logic [31:0] i_bus_addr;
    logic [31:0] i_bus_wdata;
    logic [31:0] o_bus_rdata;
    logic        o_cmd_valid;
    logic        i_cmd_ready;
    logic [31:0] o_cmd_data;
    logic        o_irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vq[$];

    mmio_cmd_queue dut (
        .clk         (clk),
        .rst         (rst),
        .i_bus_we    (i_bus_we),
        .i_bus_addr  (i_bus_addr),
        .i_bus_wdata (i_bus_wdata),
        .o_bus_rdata (o_bus_rdata),
        .o_cmd_valid (o_cmd_valid),
        .i_cmd_ready (i_cmd_ready),
        .o_cmd_data  (o_cmd_data),
        .o_irq       (o_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic rdy);
        i_bus_we    = we;
        i_bus_addr  = addr;
        i_bus_wdata = wd;
        i_cmd_ready = rdy;
        @(posedge clk);
        #1;
        i_bus_we    = 1'b0;
    endtask

    task automatic rd_status(input string name, input logic [31:0] exp);
        cyc(1'b0, A_STAT, 32'h0, 1'b0);
        check(name, o_bus_rdata, exp);
    endtask

    task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic rdy,
                       input logic ev, input logic [31:0] ed, input logic [31:0] er);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wd; v.ready = rdy;
        v.exp_valid = ev; v.exp_data = ed; v.exp_rdata = er;
        vq.push_back(v);
    endtask

    initial begin
        rst         = 1'b1;
        i_bus_we    = 1'b0;
        i_bus_addr  = 32'h0;
        i_bus_wdata = 32'h0;
        i_cmd_ready = 1'b0;

        // preload while disabled, enable, stream out back-to-back
        add(1, A_PUSH, 32'hA1, 1, 0, 32'hA1, 32'h0);
        add(1, A_PUSH, 32'hA2, 1, 0, 32'hA1, 32'h0);
        add(0, A_STAT, 32'h0,  1, 0, 32'hA1, 32'h002);
        add(1, A_CTRL, 32'h1,  1, 1, 32'hA1, 32'h0);
        add(0, A_STAT, 32'h0,  1, 1, 32'hA2, 32'h802);
        add(0, A_STAT, 32'h0,  1, 0, 32'h0,  32'h801);
        add(0, A_STAT, 32'h0,  1, 0, 32'h0,  32'h900);
        add(1, A_CTRL, 32'h0,  1, 0, 32'h0,  32'h1);
        add(0, A_STAT, 32'h0,  1, 0, 32'h0,  32'h100);
        // disable while the consumer stalls: hold the head in DRAIN
        add(1, A_CTRL, 32'h1,  0, 0, 32'h0,  32'h0);
        add(1, A_PUSH, 32'h55, 0, 1, 32'h55, 32'h0);
        add(1, A_CTRL, 32'h0,  0, 1, 32'h55, 32'h1);
        add(0, A_STAT, 32'h0,  0, 1, 32'h55, 32'h1001);
        add(0, A_STAT, 32'h0,  1, 0, 32'h0,  32'h1001);
        add(0, A_STAT, 32'h0,  1, 0, 32'h0,  32'h100);

        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", o_bus_rdata, 32'h0);
        check("rst_valid", {31'h0, o_cmd_valid}, 32'h0);
        check("rst_data",  o_cmd_data, 32'h0);
        check("rst_irq",   {31'h0, o_irq}, 32'h0);
        rst = 1'b0;

        rd_status("reset_status", 32'h100);
        check("reset_valid", {31'h0, o_cmd_valid}, 32'h0);
        check("reset_irq",   {31'h0, o_irq}, 32'h0);
        cyc(0, A_THR, 32'h0, 0);
        check("reset_thresh", o_bus_rdata, EXP_THR_RST);
        cyc(0, 32'h0000_2004, 32'h0, 0);
        check("miss_read", o_bus_rdata, 32'h0);

        foreach (vq[i]) begin
            cyc(vq[i].we, vq[i].addr, vq[i].wdata, vq[i].ready);
            check($sformatf("vec%0d_valid", i), {31'h0, o_cmd_valid}, {31'h0, vq[i].exp_valid});
            check($sformatf("vec%0d_data", i), o_cmd_data, vq[i].exp_data);
            check($sformatf("vec%0d_rdata", i), o_bus_rdata, vq[i].exp_rdata);
        end

        // overflow: 17 pushes into a 16-deep queue, word 17 dropped
        for (int i = 1; i <= 17; i++) cyc(1, A_PUSH, 32'hB000_0000 + i, 0);
        cyc(1, 32'h0000_2000, 32'hDEAD, 0);
        rd_status("ovf_status", 32'h610);
        check("ovf_head",  o_cmd_data, 32'hB000_0001);
        check("ovf_valid", {31'h0, o_cmd_valid}, 32'h0);
        cyc(1, A_CTRL, 32'h8, 0);
        rd_status("ovf_clr", 32'h210);

        // full queue: push with a simultaneous pop is accepted
        cyc(1, A_CTRL, 32'h1, 0);
        check("run_valid", {31'h0, o_cmd_valid}, 32'h1);
        cyc(1, A_PUSH, 32'hC0, 1);
        check("full_pp_head", o_cmd_data, 32'hB000_0002);
        rd_status("full_pp_status", 32'hA10);

        // flush with a stalled head keeps that head
        cyc(1, A_CTRL, 32'h3, 0);
        check("fkeep_valid", {31'h0, o_cmd_valid}, 32'h1);
        check("fkeep_head",  o_cmd_data, 32'hB000_0002);
        rd_status("fkeep_status", 32'h801);
        for (int i = 1; i <= 3; i++) cyc(1, A_PUSH, 32'hD0 + i, 0);
        rd_status("four_status", 32'h804);
        check("four_head", o_cmd_data, 32'hB000_0002);
        // flush while the head is being accepted discards everything
        cyc(1, A_CTRL, 32'h3, 1);
        check("fall_valid", {31'h0, o_cmd_valid}, 32'h0);
        rd_status("fall_status", 32'h900);
        cyc(1, A_CTRL, 32'h0, 0);
        rd_status("dis_status", 32'h100);

        // asynchronous reset mid-stream
        cyc(1, A_PUSH, 32'hF1, 0);
        cyc(1, A_PUSH, 32'hF2, 0);
        cyc(1, A_CTRL, 32'h1, 0);
        cyc(0, A_STAT, 32'h0, 0);
        check("pre_rst_valid", {31'h0, o_cmd_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'h0, o_cmd_valid}, 32'h0);
        check("mid_rst_data",  o_cmd_data, 32'h0);
        check("mid_rst_rdata", o_bus_rdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        rd_status("post_rst_status", 32'h100);
        cyc(0, A_CTRL, 32'h0, 0);
        check("post_rst_ctrl", o_bus_rdata, 32'h0);

`ifdef MMIO_CMD_QUEUE_IRQ_EN
        cyc(1, A_THR, 32'h3, 0);
        cyc(1, A_CTRL, 32'h5, 0);
        cyc(0, A_THR, 32'h0, 0);
        check("irq_thresh_rd", o_bus_rdata, 32'h3);
        cyc(0, A_CTRL, 32'h0, 0);
        check("irq_ctrl_rd", o_bus_rdata, 32'h5);
        cyc(1, A_PUSH, 32'hE1, 0);
        cyc(1, A_PUSH, 32'hE2, 0);
        cyc(1, A_PUSH, 32'hE3, 0);
        check("irq_at_count3", {31'h0, o_irq}, 32'h0);
        cyc(0, A_STAT, 32'h0, 0);
        check("irq_rise", {31'h0, o_irq}, 32'h1);
        cyc(0, A_STAT, 32'h0, 1);
        check("irq_hold", {31'h0, o_irq}, 32'h1);
        cyc(0, A_STAT, 32'h0, 0);
        check("irq_fall", {31'h0, o_irq}, 32'h0);
`else
        cyc(1, A_THR, 32'h5, 0);
        cyc(0, A_THR, 32'h0, 0);
        check("noirq_thresh", o_bus_rdata, 32'h0);
        cyc(1, A_CTRL, 32'h4, 0);
        cyc(0, A_CTRL, 32'h0, 0);
        check("noirq_ctrl", o_bus_rdata, 32'h0);
        check("noirq_irq", {31'h0, o_irq}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
